// File: rtl/result_packer.sv
// Packs an 8-bit result stream into PKT_BYTES-wide packets with one fill buffer and one holding
// register. Optional checksum enabled by defining RESULT_PACKER_CHECKSUM_EN.
module result_packer #(
  parameter int unsigned PKT_BYTES = 256,
  parameter int unsigned LEN_W     = $clog2(PKT_BYTES + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [7:0]             res_i,
  input  logic                   res_valid_i,
  input  logic                   flush_i,
  output logic [PKT_BYTES*8-1:0] pkt_o,
  output logic [LEN_W-1:0]       pkt_len_o,
  output logic [7:0]             pkt_csum_o,
  output logic                   pkt_valid_o,
  input  logic                   pkt_ready_i,
  output logic                   overflow_o,
  output logic [15:0]            drop_cnt_o
);

  localparam int unsigned PW = PKT_BYTES * 8;
  localparam logic [LEN_W-1:0] FullCnt = LEN_W'(PKT_BYTES);

  typedef enum logic {StFill, StWait} state_e;

  state_e state_q, state_d;

  logic [PW-1:0]    fill_q, fill_d, fill_wr;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_wr;
  logic [PW-1:0]    pkt_q, pkt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_q, drop_d;

  logic hs, hold_free, accept, seal, load;

  assign hs        = valid_q & pkt_ready_i;
  assign hold_free = ~valid_q | hs;
  assign accept    = (state_q == StFill) & res_valid_i;
  assign cnt_wr    = cnt_q + LEN_W'(1);
  // A byte arriving with the flush is included before sealing.
  assign seal      = (state_q == StFill) &
                     ((accept & (cnt_wr == FullCnt)) |
                      (flush_i & ((cnt_q != '0) | accept)));
  assign load      = (seal & hold_free) | ((state_q == StWait) & hs);

  always_comb begin
    fill_wr = fill_q;
    for (int unsigned k = 0; k < PKT_BYTES; k++) begin
      if (cnt_q == LEN_W'(k)) fill_wr[8*k +: 8] = res_i;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= StFill;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: if (seal && !hold_free) state_d = StWait;
      StWait: if (hs) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // Datapath next values
  always_comb begin
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    pkt_d      = pkt_q;
    len_d      = len_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          fill_d = fill_wr;
          cnt_d  = cnt_wr;
        end
        if (seal && hold_free) begin
          pkt_d  = accept ? fill_wr : fill_q;
          len_d  = accept ? cnt_wr : cnt_q;
          fill_d = '0;
          cnt_d  = '0;
        end
      end
      StWait: begin
        if (hs) begin
          pkt_d  = fill_q;
          len_d  = cnt_q;
          fill_d = '0;
          cnt_d  = '0;
          // Byte on the release edge starts the next packet instead of being dropped.
          if (res_valid_i) begin
            fill_d[7:0] = res_i;
            cnt_d       = LEN_W'(1);
          end
        end else if (res_valid_i) begin
          overflow_d = 1'b1;
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
      end
      default: ;
    endcase
    valid_d = load | (valid_q & ~hs);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      fill_q     <= '0;
      cnt_q      <= '0;
      pkt_q      <= '0;
      len_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      pkt_q      <= pkt_d;
      len_q      <= len_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

`ifdef RESULT_PACKER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d, hcsum_q, hcsum_d;

  always_comb begin
    csum_d  = csum_q;
    hcsum_d = hcsum_q;
    if (load) begin
      hcsum_d = accept ? (csum_q ^ res_i) : csum_q;
      csum_d  = ((state_q == StWait) && res_valid_i) ? res_i : 8'h00;
    end else if (accept) begin
      csum_d = csum_q ^ res_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      csum_q  <= 8'h00;
      hcsum_q <= 8'h00;
    end else begin
      csum_q  <= csum_d;
      hcsum_q <= hcsum_d;
    end
  end

  assign pkt_csum_o = hcsum_q;
`else
  assign pkt_csum_o = 8'h00;
`endif

  assign pkt_o       = pkt_q;
  assign pkt_len_o   = len_q;
  assign pkt_valid_o = valid_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_q;

endmodule
